// File: rtl/instr_ctrl_dec.sv
// Pipeline-stage instruction holder with a MIPS-subset control decoder.
// Optional macro CTRL_DEC_ILLEGAL_EN enables the illegal-encoding flag (tied to 0 otherwise).
module instr_ctrl_dec (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] nI,
    output logic [31:0] I,
    output logic        R,
    output logic        addu,
    output logic        subu,
    output logic        lw,
    output logic        sw,
    output logic        ori,
    output logic        lui,
    output logic        addi,
    output logic        beq,
    output logic        j,
    output logic        jal,
    output logic        jr,
    output logic        jalr,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        JumpReg,
    output logic        MemWrite,
    output logic        illegal
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    logic [31:0] i_q;
    logic [31:0] i_d;
    logic [5:0]  op;
    logic [5:0]  fn;

    assign i_d = en ? nI : i_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q <= '0;
        end else begin
            i_q <= i_d;
        end
    end

    assign I  = i_q;
    assign op = i_q[31:26];
    assign fn = i_q[5:0];

    // NOTE: every flag gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        addu = 1'b0;
        subu = 1'b0;
        lw   = 1'b0;
        sw   = 1'b0;
        ori  = 1'b0;
        lui  = 1'b0;
        addi = 1'b0;
        beq  = 1'b0;
        j    = 1'b0;
        jal  = 1'b0;
        jr   = 1'b0;
        jalr = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU: addu = 1'b1;
                    FN_SUBU: subu = 1'b1;
                    FN_JR:   jr   = 1'b1;
                    FN_JALR: jalr = 1'b1;
                    default: ;
                endcase
            end
            OP_LW:   lw   = 1'b1;
            OP_SW:   sw   = 1'b1;
            OP_ORI:  ori  = 1'b1;
            OP_LUI:  lui  = 1'b1;
            OP_ADDI: addi = 1'b1;
            OP_BEQ:  beq  = 1'b1;
            OP_J:    j    = 1'b1;
            OP_JAL:  jal  = 1'b1;
            default: ;
        endcase
    end

    assign R        = addu | subu;
    assign RegDst   = (R | jalr) ? DST_RD : (jal ? DST_RA : DST_RT);
    assign RegWrite = R | jalr | lw | ori | lui | addi | jal;
    assign Branch   = beq;
    assign Jump     = j | jal;
    assign JumpReg  = jr | jalr;
    assign MemWrite = sw;

`ifdef CTRL_DEC_ILLEGAL_EN
    // The all-zero word is sll $0,$0,0 (nop) and must not be flagged.
    assign illegal = (i_q != 32'd0) &&
                     !(addu | subu | lw | sw | ori | lui | addi | beq | j | jal | jr | jalr);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_ctrl_dec.sv
// Self-checking bench for instr_ctrl_dec: mnemonic-level reference model checked every cycle,
// plus hand-computed literal checks on the directed vectors.
module tb_instr_ctrl_dec;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] nI;
    logic [31:0] I;
    logic        R, addu, subu, lw, sw, ori, lui, addi, beq, j, jal, jr, jalr;
    logic [1:0]  RegDst;
    logic        RegWrite, Branch, Jump, JumpReg, MemWrite, illegal;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_i;
    bit          cmp_on = 0;

    instr_ctrl_dec dut (
        .clk(clk), .reset(reset), .en(en), .nI(nI), .I(I),
        .R(R), .addu(addu), .subu(subu), .lw(lw), .sw(sw), .ori(ori), .lui(lui),
        .addi(addi), .beq(beq), .j(j), .jal(jal), .jr(jr), .jalr(jalr),
        .RegDst(RegDst), .RegWrite(RegWrite), .Branch(Branch), .Jump(Jump),
        .JumpReg(JumpReg), .MemWrite(MemWrite), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: name the instruction, then derive every output from the mnemonic.
    function automatic string mnemonic(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (w == 32'd0) return "nop";
        if (op == 6'd0) begin
            if (fn == 6'h21) return "addu";
            if (fn == 6'h23) return "subu";
            if (fn == 6'h08) return "jr";
            if (fn == 6'h09) return "jalr";
            return "bad";
        end
        if (op == 6'h23) return "lw";
        if (op == 6'h2B) return "sw";
        if (op == 6'h0D) return "ori";
        if (op == 6'h0F) return "lui";
        if (op == 6'h08) return "addi";
        if (op == 6'h04) return "beq";
        if (op == 6'h02) return "j";
        if (op == 6'h03) return "jal";
        return "bad";
    endfunction

    // Packed order: R,addu,subu,lw,sw,ori,lui,addi,beq,j,jal,jr,jalr,RegDst[1:0],RegWrite,Branch,Jump,JumpReg,MemWrite,illegal
    function automatic logic [20:0] model_vec(input logic [31:0] w);
        string m;
        logic  rt, wr, ill;
        logic [1:0] dst;
        m   = mnemonic(w);
        rt  = (m == "addu") || (m == "subu");
        wr  = rt || (m == "jalr") || (m == "lw") || (m == "ori") || (m == "lui") ||
              (m == "addi") || (m == "jal");
        dst = (rt || m == "jalr") ? 2'd1 : (m == "jal") ? 2'd2 : 2'd0;
`ifdef CTRL_DEC_ILLEGAL_EN
        ill = (m == "bad");
`else
        ill = 1'b0;
`endif
        return {rt, m == "addu", m == "subu", m == "lw", m == "sw", m == "ori", m == "lui",
                m == "addi", m == "beq", m == "j", m == "jal", m == "jr", m == "jalr",
                dst, wr, m == "beq", (m == "j") || (m == "jal"),
                (m == "jr") || (m == "jalr"), m == "sw", ill};
    endfunction

    logic [20:0] dut_vec;
    assign dut_vec = {R, addu, subu, lw, sw, ori, lui, addi, beq, j, jal, jr, jalr,
                      RegDst, RegWrite, Branch, Jump, JumpReg, MemWrite, illegal};

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_I", I, exp_i);
            check("cyc_ctrl", dut_vec, model_vec(exp_i));
        end
    end

    task automatic step(input logic e, input logic [31:0] w);
        en = e;
        nI = w;
        @(posedge clk);
        if (!reset && e) exp_i = w;
        #1;
    endtask

    logic [31:0] vecs [12];

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        nI    = 32'h8C000000;
        exp_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 1;
        check("rst_I", I, 32'd0);
        check("rst_all", dut_vec, 21'd0);

        reset = 1'b0;
        step(1'b1, 32'h8C000000);
        check("lw_flag", lw, 1);
        check("lw_regwrite", RegWrite, 1);
        check("lw_regdst", RegDst, 0);

        step(1'b1, 32'h00221821);
        check("addu_flags", {addu, R}, 2'b11);
        check("addu_regdst", RegDst, 1);
        check("addu_regwrite", RegWrite, 1);

        step(1'b1, 32'h0C000000);
        check("jal_flag", jal, 1);
        check("jal_regdst", RegDst, 2);
        check("jal_jump", Jump, 1);

        step(1'b0, 32'hAC000000);
        check("hold_I", I, 32'h0C000000);
        check("hold_jal", jal, 1);
        step(1'b1, 32'hAC000000);
        check("sw_flags", {sw, MemWrite, RegWrite}, 3'b110);

        step(1'b1, 32'h03E00008);
        check("jr_ctrl", {JumpReg, RegWrite}, 2'b10);
        step(1'b1, 32'h03E0F809);
        check("jalr_ctrl", {RegDst, RegWrite, JumpReg}, 4'b0111);

        step(1'b1, 32'hFC000000);
        check("bad_flags", dut_vec[20:8], 13'd0);
`ifdef CTRL_DEC_ILLEGAL_EN
        check("bad_illegal", illegal, 1);
`else
        check("bad_illegal", illegal, 0);
`endif
        step(1'b1, 32'h00000000);
        check("nop_illegal", illegal, 0);
        check("nop_all", dut_vec, 21'd0);

        vecs = '{32'h3422BEEF, 32'h3C01FFFF, 32'h2063FFFC, 32'h0800ABCD,
                 32'h00A4302B, 32'h01094823, 32'h00221820, 32'h8FFFFFFF,
                 32'hAFFFFFFF, 32'h0000000C, 32'h1001FFFF, 32'h10000000};
        foreach (vecs[k]) step(1'b1, vecs[k]);
        check("beq_before_rst", Branch, 1);

        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_i = 32'd0;
        #1;
        check("async_rst_branch", Branch, 0);
        check("async_rst_I", I, 32'd0);
        step(1'b1, 32'h10000000);
        check("rst_held_I", I, 32'd0);
        reset = 1'b0;
        step(1'b1, 32'h10000000);
        check("post_rst_beq", Branch, 1);
        step(1'b1, 32'h00000000);

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
